// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus memory responder.
//
// Handshake: the initiator raises i_bus_vaild and holds it, together with
// write_enable/address/data, until it sees o_bus_ready. The responder samples
// the request only on the accept edge (IDLE with vaild high), holds o_bus_busy
// while the request waits, and pulses o_bus_ready for exactly one cycle.
// o_bus_data_read is meaningful only during that ready cycle and is 0 otherwise.
package bus_pkg;

    localparam int BUS_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic        write_enable;
        logic [31:0] address;
        logic [31:0] data;
    } bus_request_t;

    // What the ready cycle has to present on the read data bus.
    typedef enum logic [1:0] {
        RESP_WRITE     = 2'd0,
        RESP_READ_HIT  = 2'd1,
        RESP_READ_MISS = 2'd2
    } bus_resp_t;

    // Window test done in 33 bits so a window ending exactly at 2^32 works
    // and an address just past the window never wraps back to word 0.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, base};
        hi = lo + span;
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/bus_responder_sram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, registered read.
// Written in the plain form FPGA tools map onto block RAM. Contents are not
// reset.
module bus_responder_sram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic                           enable,
    input  logic                           write_enable,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [31:0]                    write_data,
    output logic [31:0]                    read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-first port: an enabled access registers the old word and may write.
    always_ff @(posedge clock) begin
        if (enable) begin
            if (write_enable) begin
                mem[index] <= write_data;
            end
            read_data <= mem[index];
        end
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Word-addressed boot/scratch memory answering the core's external bus.
// Fixed address window, programmable wait states, fixed data for misses.
// Accept at edge N gives o_bus_ready during the cycle after edge N+WAIT_STATES;
// one transfer completes every WAIT_STATES+2 cycles.
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] MISS_DATA    = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_bus_vaild,
    output logic        o_bus_ready,
    output logic        o_bus_busy,
    input  logic        i_bus_write_enable,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_data_read,
    input  logic [31:0] i_bus_data_write
);

    localparam int          INDEX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned WINDOW_BYTES = DEPTH_WORDS * BUS_WORD_BYTES;
    localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_STATES);

    bus_state_t   state;
    bus_state_t   state_next;
    logic [3:0]   wait_count;
    logic [3:0]   wait_count_next;
    bus_request_t request;
    bus_request_t request_next;
    bus_resp_t    resp_kind;
    bus_resp_t    resp_kind_next;

    bus_request_t       active;
    logic               finish;
    logic               hit;
    logic [31:0]        offset;
    logic [INDEX_W-1:0] sram_index;
    logic               sram_enable;
    logic               sram_write;
    logic [31:0]        sram_read_data;

    // Request being decoded this cycle: live inputs while idle (needed for the
    // zero-wait case, where the array is accessed on the accept edge itself),
    // otherwise the copy latched at accept so later input changes are ignored.
    always_comb begin
        active     = (state == IDLE) ? {i_bus_write_enable, i_bus_address, i_bus_data_write}
                                     : request;
        hit        = addr_in_window(active.address, BASE_ADDRESS, 33'(WINDOW_BYTES));
        offset     = active.address - BASE_ADDRESS;
        sram_index = INDEX_W'(offset >> 2);
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESPOND.
    always_comb begin
        state_next      = state;
        wait_count_next = wait_count;
        request_next    = request;
        resp_kind_next  = resp_kind;
        finish          = 1'b0;
        case (state)
            IDLE: begin
                if (i_bus_vaild) begin
                    request_next    = active;
                    wait_count_next = WAIT_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESPOND;
                        finish     = 1'b1;
                    end
                end
            end
            WAIT: begin
                wait_count_next = wait_count - 4'd1;
                if (wait_count == 4'd1) begin
                    state_next = RESPOND;
                    finish     = 1'b1;
                end
            end
            RESPOND: begin
                // Never re-accept here, even if vaild is still high.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (finish) begin
            if (active.write_enable) begin
                resp_kind_next = RESP_WRITE;
            end else if (hit) begin
                resp_kind_next = RESP_READ_HIT;
            end else begin
                resp_kind_next = RESP_READ_MISS;
            end
        end
    end

    // State, counter and latched request; reset abandons any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= 4'd0;
            request    <= '0;
            resp_kind  <= RESP_WRITE;
        end else begin
            state      <= state_next;
            wait_count <= wait_count_next;
            request    <= request_next;
            resp_kind  <= resp_kind_next;
        end
    end

    // The array is touched only on the edge entering RESPOND. Gating with reset
    // keeps a clock edge during reset from committing a write.
    always_comb begin
        sram_enable = finish && reset;
        sram_write  = active.write_enable && hit;
    end

    bus_responder_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clock       (clock),
        .enable      (sram_enable),
        .write_enable(sram_write),
        .index       (sram_index),
        .write_data  (active.data),
        .read_data   (sram_read_data)
    );

    // Outputs decode registered state, so they clear at once on reset.
    always_comb begin
        o_bus_ready     = (state == RESPOND);
        o_bus_busy      = (state == WAIT);
        o_bus_data_read = 32'h0;
        if (state == RESPOND) begin
            case (resp_kind)
                RESP_READ_HIT:  o_bus_data_read = sram_read_data;
                RESP_READ_MISS: o_bus_data_read = MISS_DATA;
                default:        o_bus_data_read = 32'h0;
            endcase
        end
    end

endmodule
